// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter sharing one sprite ROM between N_REQ renderers
//
// Ports:
//   vga_clk      pixel clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   req          per-requester level read request
//   req_addr     packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt          one-hot registered grant pulse
//   rom_address  registered address to the shared ROM
//   rom_q        ROM data output
//   rd_valid     rd_data carries the result of an earlier grant
//   rd_id        requester index belonging to rd_data
//   rd_data      ROM data, combinational pass-through of rom_q
//   busy         a grant is out or a read is still travelling to rd_*
//
// Build option: define SPRITE_ARB_FIXED_PRIO_EN for strict fixed priority
// (lowest index wins, no round-robin pointer).

module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    output logic [N_REQ-1:0]           gnt,
    output logic [ADDR_W-1:0]          rom_address,
    input  logic [DATA_W-1:0]          rom_q,
    output logic                       rd_valid,
    output logic [$clog2(N_REQ)-1:0]   rd_id,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    logic                w_any;
    logic [ID_W-1:0]     w_win;
    logic [N_REQ-1:0]    w_gnt_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;

    logic [N_REQ-1:0]    r_gnt;
    logic [ADDR_W-1:0]   r_rom_address;
    logic [ROM_LAT-1:0]  r_pipe_vld;
    logic [ID_W-1:0]     r_pipe_id [ROM_LAT];
    logic                r_rd_valid;
    logic [ID_W-1:0]     r_rd_id;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]     r_ptr;
    logic                w_found;
    int                  w_idx;
`endif

    // Winner selection
    always_comb begin
        w_any = |req;
        w_win = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        // Descending scan so the lowest set index is the last to overwrite.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ID_W'(k)]) begin
                w_win = ID_W'(k);
            end
        end
`else
        w_found = 1'b0;
        w_idx   = 0;
        // Scan ptr, ptr+1, ... modulo N_REQ; first set bit wins.
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && req[ID_W'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_idx);
            end
        end
`endif
    end

    // One-hot grant vector and address mux for the winner
    always_comb begin
        w_gnt_nxt  = '0;
        w_addr_nxt = r_rom_address;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_any && (w_win == ID_W'(k))) begin
                w_gnt_nxt[k] = 1'b1;
                w_addr_nxt   = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Grant, address and pointer registers
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt         <= '0;
            r_rom_address <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            r_ptr         <= '0;
`endif
        end else begin
            r_gnt         <= w_gnt_nxt;
            r_rom_address <= w_addr_nxt;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            if (w_any) begin
                r_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            end
`endif
        end
    end

    // Latency pipeline: stage 0 is loaded on the grant edge, so stage k is
    // valid k cycles after gnt; the output register adds the final cycle so
    // rd_valid lines up with rom_q ROM_LAT cycles after the gnt cycle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                r_pipe_id[k] <= '0;
            end
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
        end else begin
            r_pipe_vld[0] <= w_any;
            r_pipe_id[0]  <= w_win;
            for (int k = 1; k < ROM_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
            r_rd_valid <= r_pipe_vld[ROM_LAT-1];
            r_rd_id    <= r_pipe_id[ROM_LAT-1];
        end
    end

    assign gnt         = r_gnt;
    assign rom_address = r_rom_address;
    assign rd_valid    = r_rd_valid;
    assign rd_id       = r_rd_id;
    assign rd_data     = rom_q;
    assign busy        = (|r_gnt) | (|r_pipe_vld) | r_rd_valid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed self-checking bench for sprite_rom_arbiter

module tb_sprite_rom_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_addr;

    logic [3:0]  gnt1, gnt2, gnt3;
    logic [7:0]  rom_address1, rom_address2, rom_address3;
    logic [3:0]  rom_q1, rom_q2, rom_q3;
    logic        rd_valid1, rd_valid2, rd_valid3;
    logic [1:0]  rd_id1, rd_id2, rd_id3;
    logic [3:0]  rd_data1, rd_data2, rd_data3;
    logic        busy1, busy2, busy3;

    int errors = 0;
    int checks = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] romf(input logic [7:0] a);
        return ~(a[3:0] ^ a[7:4]);
    endfunction

    // ROM models: address captured on an edge, q valid ROM_LAT edges later
    logic [3:0] q1_d0;
    logic [3:0] q2_d0, q2_d1;
    logic [3:0] q3_d0, q3_d1, q3_d2;
    always @(posedge vga_clk) begin
        q1_d0 <= romf(rom_address1);
        q2_d0 <= romf(rom_address2);
        q2_d1 <= q2_d0;
        q3_d0 <= romf(rom_address3);
        q3_d1 <= q3_d0;
        q3_d2 <= q3_d1;
    end
    assign rom_q1 = q1_d0;
    assign rom_q2 = q2_d1;
    assign rom_q3 = q3_d2;

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(1)) u1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt1), .rom_address(rom_address1), .rom_q(rom_q1),
        .rd_valid(rd_valid1), .rd_id(rd_id1), .rd_data(rd_data1), .busy(busy1));

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(2)) u2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt2), .rom_address(rom_address2), .rom_q(rom_q2),
        .rd_valid(rd_valid2), .rd_id(rd_id2), .rd_data(rd_data2), .busy(busy2));

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(4), .ROM_LAT(3)) u3 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt3), .rom_address(rom_address3), .rom_q(rom_q3),
        .rd_valid(rd_valid3), .rd_id(rd_id3), .rd_data(rd_data3), .busy(busy3));

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 4'b0000;
        req_addr = 32'h0;
        tick();
        tick();
        chk("rst_gnt",      gnt1,         4'b0000);
        chk("rst_rom_addr", rom_address1, 8'h00);
        chk("rst_rd_valid", rd_valid1,    1'b0);
        chk("rst_rd_id",    rd_id1,       2'd0);
        chk("rst_busy",     busy1,        1'b0);

        // Single request from requester 1
        reset_n = 1'b1;
        req = 4'b0010;
        req_addr[1*8 +: 8] = 8'h2A;
        tick();
        chk("t1_gnt",      gnt1,         4'b0010);
        chk("t1_rom_addr", rom_address1, 8'h2A);
        chk("t1_busy",     busy1,        1'b1);
        chk("t1_nvalid",   rd_valid1,    1'b0);
        req = 4'b0000;
        tick();
        chk("t1_rd_valid", rd_valid1,    1'b1);
        chk("t1_rd_id",    rd_id1,       2'd1);
        chk("t1_rd_data",  rd_data1,     4'h7);
        chk("t1_gnt_off",  gnt1,         4'b0000);
        chk("t1_addr_hold", rom_address1, 8'h2A);
        tick();
        chk("t1_idle_valid", rd_valid1,  1'b0);
        chk("t1_idle_busy",  busy1,      1'b0);

`ifdef SPRITE_ARB_FIXED_PRIO_EN
        // Lowest index always wins
        req = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fp_gnt_0110", gnt1, 4'b0010);
        end
        req = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("fp_gnt_1001", gnt1, 4'b0001);
        end
        req = 4'b0000;
        tick();
`else
        // All four requesting from reset: strict rotation 0,1,2,3
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) req_addr[i*8 +: 8] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_gnt",      gnt1,         32'(1) << (k % 4));
            chk("t2_rom_addr", rom_address1, 32'h10 + 32'(k % 4));
            if (k >= 1) begin
                chk("t2_rd_valid", rd_valid1, 1'b1);
                chk("t2_rd_id",    rd_id1,    32'((k - 1) % 4));
                chk("t2_rd_data",  rd_data1,  romf(8'h10 + 8'((k - 1) % 4)));
            end
        end

        // Requesters 0 and 3 alternate from ptr=0
        req = 4'b1001;
        tick(); chk("t3_gnt_a", gnt1, 4'b0001);
        tick(); chk("t3_gnt_b", gnt1, 4'b1000);
        tick(); chk("t3_gnt_c", gnt1, 4'b0001);
        tick(); chk("t3_gnt_d", gnt1, 4'b1000);
        // Grant 2 moves ptr to 3, so 3 beats 0
        req = 4'b0100;
        tick(); chk("t3_gnt_2", gnt1, 4'b0100);
        req = 4'b1001;
        tick(); chk("t3_wrap_3", gnt1, 4'b1000);
        tick(); chk("t3_wrap_0", gnt1, 4'b0001);

        // Requester 0 loses to 1 and drops its request: nothing lingers
        req = 4'b0011;
        tick(); chk("drop_gnt1", gnt1, 4'b0010);
        req = 4'b0000;
        tick();
        chk("drop_no_gnt", gnt1,      4'b0000);
        chk("drop_rd_id",  rd_id1,    2'd1);
        tick();
        chk("drop_still_no_gnt", gnt1, 4'b0000);

        // Lone requester is granted every cycle
        req = 4'b0100;
        req_addr[2*8 +: 8] = 8'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("single_gnt", gnt1, 4'b0100);
        end
        req = 4'b0000;
        repeat (4) tick();
        chk("idle_busy3", busy3, 1'b0);

        // Back-to-back reads through a 3-cycle ROM
        req = 4'b0100;
        req_addr[2*8 +: 8] = 8'd10;
        tick();
        chk("t4_gnt",  gnt3,         4'b0100);
        chk("t4_addr0", rom_address3, 8'd10);
        req_addr[2*8 +: 8] = 8'd11;
        tick();
        chk("t4_addr1", rom_address3, 8'd11);
        req_addr[2*8 +: 8] = 8'd12;
        tick();
        chk("t4_not_yet", rd_valid3, 1'b0);
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_rd_valid", rd_valid3, 1'b1);
            chk("t4_rd_id",    rd_id3,    2'd2);
            chk("t4_rd_data",  rd_data3,  romf(8'd10 + 8'(k)));
        end
        tick();
        chk("t4_rd_done", rd_valid3, 1'b0);
        repeat (2) tick();
`endif

        // Reset one cycle after a grant discards the read (ROM_LAT=2)
        req = 4'b0001;
        req_addr[0*8 +: 8] = 8'h33;
        tick();
        chk("t5_gnt", gnt2, 4'b0001);
        req = 4'b0000;
        tick();
        chk("t5_busy_pre", busy2, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_gnt",      gnt2,         4'b0000);
        chk("t5_rst_rom_addr", rom_address2, 8'h00);
        chk("t5_rst_rd_valid", rd_valid2,    1'b0);
        chk("t5_rst_rd_id",    rd_id2,       2'd0);
        chk("t5_rst_busy",     busy2,        1'b0);
        tick();
        chk("t5_rst_hold_valid", rd_valid2, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_post_valid", rd_valid2, 1'b0);
        end
        chk("t5_post_busy", busy2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
